// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame sequencer: state encoding,
// default start-of-frame marker and width helpers.
package uart_frame_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } frame_state_e;

    // Default start-of-frame marker
    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

    // Counter width able to hold 0 .. cycles-1 (never narrower than one bit)
    function automatic int timer_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Index width able to address 0 .. count-1 (never narrower than one bit)
    function automatic int index_width(input int count);
        int w;
        w = $clog2(count);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_gap_timer.sv
// Inter-byte gap timer. Counts cycles while enabled, restarts on clear,
// and raises expire in the cycle the count reaches TIMEOUT_CYC-1 without
// a clear. A clear in the expiry cycle suppresses the expiry.
module frame_gap_timer
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int               CNT_W    = timer_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;

    assign expire = en & ~clr & (cnt_r == CNT_LAST);

    // Gap counter: restarts on a byte, when idle, or after it has expired
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clr || !en || expire) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame-level sequencer between a UART byte receiver and a wide consumer.
// Hunts for a header byte, gathers NUM_BYTES payload bytes (first byte in
// the low lane), verifies a trailing XOR checksum and then holds the word
// on a valid/ready handshake. Gap timeouts, checksum mismatches and bytes
// arriving while a word is held are reported as one-cycle error pulses.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE    = DEFAULT_HDR_BYTE,
    parameter int         NUM_BYTES   = 8,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_chksum,
    output logic                   err_overrun,
    output logic [15:0]            frame_cnt
);

    localparam int               IDX_W    = index_width(NUM_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    frame_state_e     state_r;
    logic             rx_done_d_r;
    logic [IDX_W-1:0] idx_r;
    logic [7:0]       chk_r;

    logic             acc_s;
    logic             hdr_s;
    logic             timer_en_s;
    logic             expire_s;

    // A byte counts once per rising edge of rx_done, however long it is held
    assign acc_s      = rx_done & ~rx_done_d_r;
    assign hdr_s      = acc_s & (rx_data == HDR_BYTE);
    assign timer_en_s = (state_r == PAYLOAD) || (state_r == CHECK);

    frame_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_s),
        .en     (timer_en_s),
        .expire (expire_s)
    );

    // Frame sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rx_done_d_r <= 1'b0;
            idx_r       <= IDX_ZERO;
            chk_r       <= 8'h00;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_chksum  <= 1'b0;
            err_overrun <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            rx_done_d_r <= rx_done;
            err_timeout <= 1'b0;
            err_chksum  <= 1'b0;
            err_overrun <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (hdr_s) begin
                        state_r <= PAYLOAD;
                        idx_r   <= IDX_ZERO;
                        chk_r   <= 8'h00;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end

                PAYLOAD: begin
                    // A header value here is ordinary payload data
                    if (acc_s) begin
                        frame_data[{idx_r, 3'b000} +: 8] <= rx_data;
                        chk_r <= chk_r ^ rx_data;
                        if (idx_r == IDX_LAST) begin
                            state_r <= CHECK;
                        end else begin
                            idx_r   <= idx_r + IDX_ONE;
                        end
                    end else if (expire_s) begin
                        err_timeout <= 1'b1;
                        state_r     <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        state_r     <= PAYLOAD;
                    end
                end

                CHECK: begin
                    if (acc_s) begin
                        if (rx_data == chk_r) begin
                            state_r     <= HOLD;
                            frame_valid <= 1'b1;
                        end else begin
                            err_chksum  <= 1'b1;
                            state_r     <= IDLE;
                            busy        <= 1'b0;
                        end
                    end else if (expire_s) begin
                        err_timeout <= 1'b1;
                        state_r     <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        state_r     <= CHECK;
                    end
                end

                HOLD: begin
                    // On a completing handshake the byte is treated as an IDLE input
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        frame_cnt   <= frame_cnt + 16'd1;
                        if (hdr_s) begin
                            state_r <= PAYLOAD;
                            idx_r   <= IDX_ZERO;
                            chk_r   <= 8'h00;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else if (acc_s) begin
                        err_overrun <= 1'b1;
                    end else begin
                        state_r     <= HOLD;
                    end
                end

                default: begin
                    state_r     <= IDLE;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed scenarios with literal
// expectations followed by randomized frames, all compared every cycle
// against a queue-based frame model.
module tb_uart_frame_ctrl;

    localparam int         NB  = 8;
    localparam int         TO  = 100;
    localparam logic [7:0] HDR = 8'hA5;

    logic            clk         = 1'b0;
    logic            rst         = 1'b1;
    logic [7:0]      rx_data     = 8'h00;
    logic            rx_done     = 1'b0;
    logic            frame_ready = 1'b0;
    logic [8*NB-1:0] frame_data;
    logic            frame_valid;
    logic            busy;
    logic            err_timeout;
    logic            err_chksum;
    logic            err_overrun;
    logic [15:0]     frame_cnt;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model state: phase 0 = hunting, 1 = collecting, 2 = holding
    int         m_phase  = 0;
    logic [7:0] m_bytes[$];
    int         m_gap    = 0;
    logic       m_done_d = 1'b0;

    logic [63:0] e_data  = 64'h0;
    logic        e_valid = 1'b0;
    logic        e_busy  = 1'b0;
    logic        e_to    = 1'b0;
    logic        e_ck    = 1'b0;
    logic        e_ov    = 1'b0;
    logic [15:0] e_cnt   = 16'h0;

    uart_frame_ctrl #(
        .HDR_BYTE    (HDR),
        .NUM_BYTES   (NB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_chksum  (err_chksum),
        .err_overrun (err_overrun),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("frame_data",  frame_data,  e_data);
        check("frame_valid", frame_valid, e_valid);
        check("busy",        busy,        e_busy);
        check("err_timeout", err_timeout, e_to);
        check("err_chksum",  err_chksum,  e_ck);
        check("err_overrun", err_overrun, e_ov);
        check("frame_cnt",   frame_cnt,   e_cnt);
    endtask

    // Predicts the outputs after the coming clock edge from the applied inputs
    task automatic model_step();
        logic       acc;
        logic [7:0] x;
        e_to = 1'b0;
        e_ck = 1'b0;
        e_ov = 1'b0;
        if (rst) begin
            m_phase  = 0;
            m_bytes.delete();
            m_gap    = 0;
            m_done_d = 1'b0;
            e_data   = 64'h0;
            e_valid  = 1'b0;
            e_busy   = 1'b0;
            e_cnt    = 16'h0;
        end else begin
            acc      = rx_done && !m_done_d;
            m_done_d = rx_done;
            if (m_phase == 0) begin
                if (acc && rx_data == HDR) begin
                    m_phase = 1;
                    m_bytes.delete();
                    m_gap   = 0;
                end
            end else if (m_phase == 1) begin
                if (acc) begin
                    m_gap = 0;
                    if (m_bytes.size() < NB) begin
                        e_data[8*m_bytes.size() +: 8] = rx_data;
                        m_bytes.push_back(rx_data);
                    end else begin
                        x = 8'h00;
                        foreach (m_bytes[i]) x = x ^ m_bytes[i];
                        if (x == rx_data) begin
                            m_phase = 2;
                            e_valid = 1'b1;
                        end else begin
                            e_ck    = 1'b1;
                            m_phase = 0;
                        end
                    end
                end else if (m_gap == TO - 1) begin
                    e_to    = 1'b1;
                    m_phase = 0;
                end else begin
                    m_gap++;
                end
            end else begin
                if (frame_ready) begin
                    e_valid = 1'b0;
                    e_cnt   = e_cnt + 16'd1;
                    m_phase = 0;
                    if (acc && rx_data == HDR) begin
                        m_phase = 1;
                        m_bytes.delete();
                        m_gap   = 0;
                    end
                end else if (acc) begin
                    e_ov = 1'b1;
                end
            end
            e_busy = (m_phase != 0);
        end
    endtask

    // One clock: check outputs of the last edge, then apply inputs for the next
    // rdy: 0 / 1 literal, 2 = random (mostly ready)
    task automatic tick(input bit r, input bit d, input logic [7:0] b, input int rdy);
        @(negedge clk);
        if (chk_en) compare_all();
        rst     = r;
        rx_done = d;
        rx_data = b;
        if (rdy == 2) frame_ready = ($urandom_range(0, 3) != 0);
        else          frame_ready = (rdy != 0);
        model_step();
    endtask

    task automatic send(input logic [7:0] b, input int rdy, input int hold, input int gap);
        repeat (hold) tick(1'b0, 1'b1, b, rdy);
        repeat (gap)  tick(1'b0, 1'b0, b, rdy);
    endtask

    task automatic send_seq_frame(input int rdy);
        send(HDR, rdy, 1, 1);
        for (int k = 1; k <= NB; k++) send(8'(k), rdy, 1, 1);
        send(8'h08, rdy, 1, 1);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] x;
        int kind;

        tick(1'b1, 1'b0, 8'h00, 0);
        tick(1'b1, 1'b0, 8'h00, 0);
        chk_en = 1'b1;
        tick(1'b0, 1'b0, 8'h00, 1);
        check("reset_valid", frame_valid, 64'h0);
        check("reset_busy",  busy,        64'h0);
        check("reset_cnt",   frame_cnt,   64'h0);
        check("reset_data",  frame_data,  64'h0);

        // Good frame with ready held high
        send_seq_frame(1);
        check("good_valid", frame_valid, 64'h1);
        check("good_data",  frame_data,  64'h0807060504030201);
        tick(1'b0, 1'b0, 8'h00, 1);
        check("good_drop", frame_valid, 64'h0);
        check("good_cnt",  frame_cnt,   64'h1);

        // Bad checksum
        send(HDR, 1, 1, 1);
        for (int k = 1; k <= NB; k++) send(8'(k), 1, 1, 1);
        send(8'h00, 1, 1, 1);
        check("chk_pulse", err_chksum,  64'h1);
        check("chk_valid", frame_valid, 64'h0);
        tick(1'b0, 1'b0, 8'h00, 1);
        check("chk_end", err_chksum, 64'h0);
        check("chk_cnt", frame_cnt,  64'h1);

        // Timeout 100 cycles after the last accepted byte
        send(HDR, 1, 1, 1);
        send(8'h11, 1, 1, 1);
        send(8'h22, 1, 1, 1);
        for (int i = 1; i <= TO; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1);
            if (i == TO - 1) begin
                check("to_early", err_timeout, 64'h0);
                check("to_busy",  busy,        64'h1);
            end
        end
        check("to_pulse", err_timeout, 64'h1);
        check("to_idle",  busy,        64'h0);
        send(HDR, 1, 1, 1);
        for (int k = 1; k <= NB; k++) send(8'(16 * k), 1, 1, 1);
        send(8'h80, 1, 1, 1);
        check("to_next_data", frame_data, 64'h8070605040302010);
        tick(1'b0, 1'b0, 8'h00, 1);
        check("to_next_cnt", frame_cnt, 64'h2);

        // Backpressure and overrun
        send_seq_frame(0);
        send(8'h55, 0, 1, 1);
        check("ovr_pulse", err_overrun, 64'h1);
        check("ovr_data",  frame_data,  64'h0807060504030201);
        tick(1'b0, 1'b0, 8'h00, 1);
        check("ovr_hold", frame_valid, 64'h1);
        tick(1'b0, 1'b0, 8'h00, 0);
        check("ovr_drop", frame_valid, 64'h0);
        check("ovr_cnt",  frame_cnt,   64'h3);

        // Ready and header edge in the same HOLD cycle
        send_seq_frame(0);
        tick(1'b0, 1'b1, HDR, 1);
        tick(1'b0, 1'b0, 8'h00, 0);
        check("sim_ovr",  err_overrun, 64'h0);
        check("sim_busy", busy,        64'h1);
        check("sim_cnt",  frame_cnt,   64'h4);
        for (int k = 1; k <= NB; k++) send(8'(k), 1, 1, 1);
        send(8'h08, 1, 1, 1);
        check("sim_valid", frame_valid, 64'h1);
        tick(1'b0, 1'b0, 8'h00, 1);

        // Reset in the middle of a frame
        send(HDR, 1, 1, 1);
        for (int k = 1; k <= 4; k++) send(8'(k), 1, 1, 1);
        tick(1'b1, 1'b0, 8'h00, 1);
        tick(1'b0, 1'b0, 8'h00, 1);
        check("mrst_cnt",  frame_cnt,  64'h0);
        check("mrst_data", frame_data, 64'h0);
        check("mrst_busy", busy,       64'h0);
        send(8'h01, 1, 1, 1);
        send(8'h02, 1, 1, 1);
        check("mrst_ignore", busy, 64'h0);
        send_seq_frame(1);
        check("mrst_good", frame_data, 64'h0807060504030201);
        tick(1'b0, 1'b0, 8'h00, 1);
        check("mrst_cnt1", frame_cnt, 64'h1);

        // Noise in IDLE
        send(8'h3C, 1, 1, 1);
        check("noise_busy", busy, 64'h0);

        // rx_done held high counts once
        send(HDR, 1, 1, 1);
        send(8'h01, 1, 20, 1);
        for (int k = 2; k <= NB; k++) send(8'(k), 1, 1, 1);
        send(8'h08, 1, 1, 1);
        check("held_valid", frame_valid, 64'h1);
        check("held_data",  frame_data,  64'h0807060504030201);
        tick(1'b0, 1'b0, 8'h00, 1);
        check("held_cnt", frame_cnt, 64'h2);

        // Randomized frames with noise, held strobes, gaps near the timeout,
        // bad checksums and random backpressure
        for (int f = 0; f < 400; f++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) send(8'($urandom_range(0, 255)), 2, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            send(HDR, 2, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
            x = 8'h00;
            for (int k = 0; k < NB; k++) begin
                b = 8'($urandom_range(0, 255));
                x = x ^ b;
                if (kind == 1 && k == 3)
                    send(b, 2, int'($urandom_range(1, 3)), TO - 3 + int'($urandom_range(0, 5)));
                else
                    send(b, 2, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
            end
            if (kind == 2) x = x ^ 8'h5A;
            send(x, 2, int'($urandom_range(1, 3)), int'($urandom_range(1, 6)));
        end
        repeat (5) tick(1'b0, 1'b0, 8'h00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
